mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
- Memory-access stage placed directly downstream of the EXE stage register. Consumes ALU_result (address), ST_val (store data), MEM_R_EN and MEM_W_EN.
- Performs 32-bit loads and stores against an external 16-bit asynchronous SRAM. Each word takes two half-word accesses, and each access holds for a fixed number of wait cycles.
- Raises freeze back to all pipeline registers until the access completes, then presents read_data to the MEM stage register.

Parameters:
- ADDR_BASE, 1024: byte address that maps to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM address width, in half-word units.
- WAIT_CYCLES, 5: cycles each half-word access is held. Legal range is 1..15.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- MEM_R_EN  in  1  load request from the EXE stage register.
- MEM_W_EN  in  1  store request from the EXE stage register.
- ALU_result  in  32  byte address.
- ST_val  in  32  store data.
- read_data  out  32  load result. Registered; holds until the next load completes.
- ready  out  1  access complete, or no request pending.
- freeze  out  1  stall all pipeline registers. Equals (MEM_R_EN|MEM_W_EN) & ~ready.
- SRAM_ADDR  out  SRAM_ADDR_W  half-word address.
- SRAM_DQ_out  out  16  write data to the pad.
- SRAM_DQ_in  in  16  read data from the pad.
- SRAM_DQ_oe  out  1  pad output enable. 1 means driving.
- SRAM_WE_N  out  1  SRAM write strobe, active-low.

Behaviour:
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE. Wait counter cnt is 4 bits.
- Reset (asynchronous, any state, including mid-access):
  - state=IDLE, cnt=0, read_data=0, addr_q=0, wdata_q=0.
  - SRAM_WE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0.
- IDLE:
  - On MEM_W_EN=1, go to WR_LO. Otherwise, on MEM_R_EN=1, go to RD_LO. If both are set, write wins.
  - On leaving IDLE, latch addr_q = (ALU_result - ADDR_BASE)[SRAM_ADDR_W:2] (word index; byte bits [1:0] ignored; subtraction wraps modulo 2^32), latch wdata_q = ST_val, and clear cnt to 0.
- Each access state lasts exactly WAIT_CYCLES cycles:
  - cnt increments every cycle.
  - The state advances when cnt==WAIT_CYCLES-1, and cnt returns to 0.
  - Order: WR_LO->WR_HI->DONE and RD_LO->RD_HI->DONE.
- SRAM outputs are decoded only from state, addr_q and wdata_q (Moore), never from live pipeline inputs:
  - WR_LO: SRAM_ADDR={addr_q,0}, SRAM_DQ_out=wdata_q[15:0], SRAM_DQ_oe=1, SRAM_WE_N=0.
  - WR_HI: SRAM_ADDR={addr_q,1}, SRAM_DQ_out=wdata_q[31:16], SRAM_DQ_oe=1, SRAM_WE_N=0.
  - RD_LO / RD_HI: address as for writes, SRAM_DQ_oe=0, SRAM_WE_N=1. On the last cycle of the state (cnt==WAIT_CYCLES-1), capture SRAM_DQ_in into read_data[15:0] or read_data[31:16] respectively.
  - IDLE / DONE: SRAM_WE_N=1, SRAM_DQ_oe=0, SRAM_ADDR holds its last value.
- ready = (state==IDLE & ~MEM_R_EN & ~MEM_W_EN) | state==DONE. ready is combinational.
- Freeze timing:
  - A request seen in IDLE freezes the pipeline in that same cycle.
  - Total freeze length is 2*WAIT_CYCLES+1 cycles. With the default parameters this is 11 cycles.
- DONE lasts one cycle:
  - ready=1, so the pipeline advances and a new instruction arrives.
  - The next state is unconditionally IDLE, so back-to-back memory instructions each pay full latency.
- Inputs are ignored outside IDLE. Request deassertion or address change mid-access does not abort or alter the access.
- A store leaves read_data unchanged.

Test Plan:
- Store: ALU_result=1024+8, ST_val=0xDEADBEEF, WAIT_CYCLES=5.
  - SRAM_ADDR=4 with SRAM_DQ_out=0xBEEF and SRAM_WE_N=0 for 5 cycles.
  - Then SRAM_ADDR=5 with SRAM_DQ_out=0xDEAD for 5 cycles.
  - freeze high for 11 cycles, ready high in DONE.
- Load: ALU_result=1032, SRAM model returns 0xBEEF at address 4 and 0xDEAD at address 5.
  - read_data=0xDEADBEEF after DONE.
  - SRAM_DQ_oe=0 throughout.
- No request (MEM_R_EN=MEM_W_EN=0) for 20 cycles -> ready=1, freeze=0, SRAM_WE_N=1, state stays IDLE.
- Back-to-back store to 1024 then load from 1024 -> each shows an 11-cycle freeze separated by one DONE cycle; load returns the stored word.
- rst pulsed during the 3rd cycle of WR_HI -> SRAM_WE_N=1, SRAM_DQ_oe=0, freeze=0 (with no request present) immediately; read_data=0.
- MEM_R_EN=MEM_W_EN=1 simultaneously -> write sequence is performed; read_data unchanged.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM-stage controller that turns 32-bit loads and stores
// into two half-word accesses on an external 16-bit asynchronous SRAM. Each
// half-word access is held for WAIT_CYCLES cycles. The pipeline is frozen
// until the access finishes.
//
// Handshake: a request is MEM_R_EN or MEM_W_EN held high by the EXE stage
// register. The controller accepts it only in IDLE. ready is high when there is
// no request, or for the single DONE cycle of a completed access. freeze is
// (MEM_R_EN | MEM_W_EN) & ~ready. While freeze is high the request and its
// operands must be held, but the controller does not rely on that: it latches
// them when it leaves IDLE.
module mem_stage_sram_ctrl #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            ALU_result,
  input  logic [31:0]            ST_val,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic                   freeze,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]            SRAM_DQ_out,
  input  logic [15:0]            SRAM_DQ_in,
  output logic                   SRAM_DQ_oe,
  output logic                   SRAM_WE_N,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    RD_LO = 3'd3,
    RD_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t                  state;
  logic [3:0]              cnt;
  logic [SRAM_ADDR_W-2:0]  addr_q;
  logic [31:0]             wdata_q;
  logic [SRAM_ADDR_W-1:0]  addr_hold;
  logic [31:0]             offset;
  logic                    cnt_last;
  logic                    req;

  // Byte offset from the SRAM window base. The subtraction wraps modulo 2^32.
  assign offset   = ALU_result - ADDR_BASE;
  assign cnt_last = (cnt == CNT_LAST);
  assign req      = MEM_R_EN | MEM_W_EN;

  // Sequencer: accept a request in IDLE, then run the two timed half-word phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      read_data <= 32'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      addr_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state   <= MEM_W_EN ? WR_LO : RD_LO;
            addr_q  <= offset[SRAM_ADDR_W:2];
            wdata_q <= ST_val;
            cnt     <= 4'd0;
          end
        end
        WR_LO: begin
          addr_hold <= SRAM_ADDR;
          if (cnt_last) begin
            state <= WR_HI;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_HI: begin
          addr_hold <= SRAM_ADDR;
          if (cnt_last) begin
            state <= DONE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_LO: begin
          addr_hold <= SRAM_ADDR;
          if (cnt_last) begin
            read_data[15:0] <= SRAM_DQ_in;
            state           <= RD_HI;
            cnt             <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_HI: begin
          addr_hold <= SRAM_ADDR;
          if (cnt_last) begin
            read_data[31:16] <= SRAM_DQ_in;
            state            <= DONE;
            cnt              <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // SRAM pad decode. It depends only on state and latched operands, so a change
  // on the pipeline inputs cannot disturb an access in flight.
  always_comb begin
    SRAM_ADDR   = addr_hold;
    SRAM_DQ_out = 16'd0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    case (state)
      WR_LO: begin
        SRAM_ADDR   = {addr_q, 1'b0};
        SRAM_DQ_out = wdata_q[15:0];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = 1'b0;
      end
      WR_HI: begin
        SRAM_ADDR   = {addr_q, 1'b1};
        SRAM_DQ_out = wdata_q[31:16];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = 1'b0;
      end
      RD_LO: SRAM_ADDR = {addr_q, 1'b0};
      RD_HI: SRAM_ADDR = {addr_q, 1'b1};
      default: ;
    endcase
  end

  // Stall handshake toward the pipeline registers.
  always_comb begin
    ready  = ((state == IDLE) && !req) || (state == DONE);
    freeze = req & ~ready;
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: directed and random loads and stores against a
// behavioural SRAM. Expected values come from a word-level reference memory
// and a cycle-phase view of each access: one request cycle, W low-half
// cycles, W high-half cycles, then one DONE cycle.
module tb_mem_stage_sram_ctrl;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_result, ST_val;
  logic [31:0] read_data;
  logic        ready, freeze;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_DQ_oe, SRAM_WE_N;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Clock and reset source.
  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.ADDR_BASE(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_result(ALU_result), .ST_val(ST_val), .read_data(read_data),
    .ready(ready), .freeze(freeze), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N), .dbg_state(dbg_state)
  );

  // Asynchronous SRAM: write on each clock edge with WE_N low; read is combinational.
  logic [15:0] sram [0:255];
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
  assign SRAM_DQ_in = sram[SRAM_ADDR[7:0]];

  // Reference model state.
  logic [31:0] ref_mem [int];
  int          written_q[$];
  logic [31:0] exp_rd = 32'd0;
  logic [17:0] last_addr = 18'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] word_idx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'd1024) >> 2;
    return d[16:0];
  endfunction

  // One memory instruction, entered just after a rising edge with the DUT in IDLE.
  // abort_k >= 0 applies reset during that cycle of the access instead of finishing.
  task automatic do_access(input bit w, input bit r, input logic [31:0] addr,
                           input logic [31:0] data, input int abort_k);
    logic [16:0] idx;
    bit          is_wr;
    int          h;
    idx   = word_idx(addr);
    is_wr = w;
    MEM_W_EN = w; MEM_R_EN = r; ALU_result = addr; ST_val = data;
    for (int k = 0; k <= 2 * W + 1; k++) begin
      if (k == abort_k) begin
        rst = 1'b1; MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
        #1;
        chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst_oe", 32'(SRAM_DQ_oe), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        if (is_wr) begin
          ref_mem[int'(idx[6:0])] = data;
          written_q.push_back(int'(idx[6:0]));
        end
        exp_rd = 32'd0; last_addr = 18'd0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      if (k == 0) begin
        chk("req_ready", 32'(ready), 32'd0);
        chk("req_freeze", 32'(freeze), 32'd1);
        chk("req_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("req_oe", 32'(SRAM_DQ_oe), 32'd0);
        chk("req_addr_hold", 32'(SRAM_ADDR), 32'(last_addr));
      end else if (k <= 2 * W) begin
        h = (k > W) ? 1 : 0;
        chk("acc_ready", 32'(ready), 32'd0);
        chk("acc_freeze", 32'(freeze), 32'd1);
        chk("acc_addr", 32'(SRAM_ADDR), 32'(idx) * 2 + 32'(h));
        chk("acc_we_n", 32'(SRAM_WE_N), is_wr ? 32'd0 : 32'd1);
        chk("acc_oe", 32'(SRAM_DQ_oe), is_wr ? 32'd1 : 32'd0);
        if (is_wr) chk("acc_dq_out", 32'(SRAM_DQ_out), h ? 32'(data[31:16]) : 32'(data[15:0]));
      end else begin
        if (is_wr) begin
          ref_mem[int'(idx[6:0])] = data;
          written_q.push_back(int'(idx[6:0]));
        end else begin
          exp_rd = ref_mem[int'(idx[6:0])];
        end
        last_addr = {idx, 1'b1};
        chk("done_ready", 32'(ready), 32'd1);
        chk("done_freeze", 32'(freeze), 32'd0);
        chk("done_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("done_oe", 32'(SRAM_DQ_oe), 32'd0);
        chk("done_addr_hold", 32'(SRAM_ADDR), 32'(last_addr));
        chk("done_read_data", read_data, exp_rd);
      end
      @(posedge clk); #1;
      // Operands wander during the access; the access must not notice.
      if (k < 2 * W + 1) begin
        ALU_result = $urandom; ST_val = $urandom;
      end
    end
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_freeze", 32'(freeze), 32'd0);
      chk("idle_we_n", 32'(SRAM_WE_N), 32'd1);
      chk("idle_oe", 32'(SRAM_DQ_oe), 32'd0);
      chk("idle_read_data", read_data, exp_rd);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int op;
    logic [31:0] a;
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_result = 32'd0; ST_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_addr", 32'(SRAM_ADDR), 32'd0);
    chk("reset_dq_out", 32'(SRAM_DQ_out), 32'd0);
    chk("reset_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("reset_oe", 32'(SRAM_DQ_oe), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_freeze", 32'(freeze), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed store then load of the same word.
    do_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, -1);
    do_access(1'b0, 1'b1, 32'd1032, 32'd0, -1);
    chk("load_deadbeef", read_data, 32'hDEADBEEF);

    // Quiet pipeline.
    idle_cycles(20);

    // Back-to-back store and load at the window base.
    do_access(1'b1, 1'b0, 32'd1024, 32'h1234_5678, -1);
    do_access(1'b0, 1'b1, 32'd1024, 32'd0, -1);
    chk("b2b_load", read_data, 32'h1234_5678);

    // Simultaneous requests: the store runs and read_data is untouched.
    do_access(1'b1, 1'b1, 32'd1040, 32'hA5A5_C3C3, -1);
    chk("both_keeps_rd", read_data, 32'h1234_5678);
    do_access(1'b0, 1'b1, 32'd1040, 32'd0, -1);
    chk("both_stored", read_data, 32'hA5A5_C3C3);

    // Reset in the third cycle of the high-half write.
    do_access(1'b1, 1'b0, 32'd1100, 32'hCAFE_F00D, W + 3);
    idle_cycles(2);

    // Address below the base wraps.
    do_access(1'b1, 1'b0, 32'd2, 32'h0BAD_F00D, -1);

    // Random traffic.
    for (int i = 0; i < 14; i++) begin
      op = $urandom_range(0, 2);
      if (op == 1 && written_q.size() > 0) begin
        a = 32'd1024 + 32'(written_q[$urandom_range(0, written_q.size() - 1)]) * 4 + 32'($urandom_range(0, 3));
        do_access(1'b0, 1'b1, a, 32'd0, -1);
      end else begin
        a = 32'd1024 + 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(0, 3));
        do_access(1'b1, op == 2, a, $urandom, -1);
      end
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
